// File: rtl/riscv_dmem_responder_if.sv
// Core-side data memory bus shared by the RV64 core and riscv_dmem_responder.
interface riscv_dmem_responder_if;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic        dmem_we;
    logic [2:0]  dmem_size;
    logic [63:0] dmem_rdata;

    modport master (
        output dmem_addr, dmem_wdata, dmem_we, dmem_size,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_addr, dmem_wdata, dmem_we, dmem_size,
        output dmem_rdata
    );
endinterface

// File: rtl/riscv_dmem_responder.sv
// Data memory for the RV64 core: on-chip RAM plus MMIO console FIFO, TOHOST and CYCLE.
// Define RISCV_DMEM_CYCLE_EN to implement the CYCLE counter; otherwise CYCLE reads 0.
module riscv_dmem_responder #(
    parameter int unsigned MEM_BYTES = 65536,
    parameter int unsigned CON_DEPTH = 8,
    parameter logic [63:0] MMIO_BASE = 64'h0000_0000_1000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    riscv_dmem_responder_if.slave  dmem,
    output logic                   con_valid,
    output logic [7:0]             con_data,
    input  logic                   con_ready,
    output logic                   con_overflow,
    output logic                   tohost_valid,
    output logic [62:0]            tohost_code
);
    localparam int unsigned WORDS = MEM_BYTES / 8;
    localparam int unsigned WAW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned PW    = $clog2(CON_DEPTH);
    localparam int unsigned CW    = PW + 1;

    logic [63:0]    addr;
    logic [63:0]    mmio_off;
    logic           ram_hit;
    logic           mmio_hit;
    logic [2:0]     byte_off;
    logic [7:0]     lane_mask;
    logic [7:0]     wmask;
    logic [63:0]    wdata_sh;
    logic [WAW-1:0] word_idx;
    logic [63:0]    ram [WORDS];
    logic [63:0]    ram_word;
    logic [63:0]    raw;
    logic [63:0]    ram_rdata;
    logic [63:0]    mmio_rdata;
    logic [63:0]    cycle_val;

    assign addr     = dmem.dmem_addr;
    assign ram_hit  = addr < 64'(MEM_BYTES);
    assign mmio_off = addr - MMIO_BASE;
    assign mmio_hit = (addr >= MMIO_BASE) && (mmio_off < 64'd32);
    assign word_idx = addr[WAW+2:3];

    // Accesses align downward to their own size, so they never cross a doubleword.
    always_comb begin
        byte_off  = 3'd0;
        lane_mask = 8'hFF;
        case (dmem.dmem_size[1:0])
            2'd0: begin byte_off = addr[2:0];          lane_mask = 8'h01; end
            2'd1: begin byte_off = {addr[2:1], 1'b0};  lane_mask = 8'h03; end
            2'd2: begin byte_off = {addr[2], 2'b00};   lane_mask = 8'h0F; end
            default: begin byte_off = 3'd0;            lane_mask = 8'hFF; end
        endcase
    end

    assign wmask    = lane_mask << byte_off;
    assign wdata_sh = dmem.dmem_wdata << {byte_off, 3'b000};

    // RAM is deliberately outside the reset domain: stores land even while rst is high.
    always_ff @(posedge clk) begin
        if (dmem.dmem_we && ram_hit) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (wmask[i]) begin
                    ram[word_idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
                end
            end
        end
    end

    assign ram_word = ram[word_idx];

    always_comb begin
        raw = ram_word >> {byte_off, 3'b000};
        case (dmem.dmem_size)
            3'd0:    ram_rdata = {{56{raw[7]}},  raw[7:0]};
            3'd1:    ram_rdata = {{48{raw[15]}}, raw[15:0]};
            3'd2:    ram_rdata = {{32{raw[31]}}, raw[31:0]};
            3'd4:    ram_rdata = {56'd0, raw[7:0]};
            3'd5:    ram_rdata = {48'd0, raw[15:0]};
            3'd6:    ram_rdata = {32'd0, raw[31:0]};
            default: ram_rdata = raw;
        endcase
    end

    // Console FIFO
    logic [7:0]    con_mem [CON_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] con_count;
    logic          con_wr;
    logic          con_full;
    logic          con_pop;
    logic          con_push;
    logic          th_wr;

    assign con_wr    = dmem.dmem_we && mmio_hit && (mmio_off[4:3] == 2'd0);
    assign th_wr     = dmem.dmem_we && mmio_hit && (mmio_off[4:3] == 2'd1);
    assign con_full  = con_count == CW'(CON_DEPTH);
    assign con_valid = con_count != '0;
    assign con_pop   = con_valid && con_ready;
    // A pop frees the slot, so a push into a full FIFO still succeeds that cycle.
    assign con_push  = con_wr && (!con_full || con_pop);
    assign con_data  = con_valid ? con_mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (con_push && !rst) begin
            con_mem[wr_ptr] <= dmem.dmem_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            con_count    <= '0;
            con_overflow <= 1'b0;
        end else begin
            if (con_push) wr_ptr <= wr_ptr + 1'b1;
            if (con_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (con_push && !con_pop)      con_count <= con_count + 1'b1;
            else if (!con_push && con_pop) con_count <= con_count - 1'b1;
            if (con_wr && con_full && !con_pop) con_overflow <= 1'b1;
        end
    end

    // TOHOST: first reported code wins until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tohost_valid <= 1'b0;
            tohost_code  <= '0;
        end else if (th_wr && dmem.dmem_wdata[0] && !tohost_valid) begin
            tohost_valid <= 1'b1;
            tohost_code  <= dmem.dmem_wdata[63:1];
        end
    end

`ifdef RISCV_DMEM_CYCLE_EN
    logic [63:0] cycle_cnt;

    always_ff @(posedge clk) begin
        if (rst) cycle_cnt <= '0;
        else     cycle_cnt <= cycle_cnt + 64'd1;
    end

    assign cycle_val = cycle_cnt;
`else
    assign cycle_val = '0;
`endif

    always_comb begin
        case (mmio_off[4:3])
            2'd0:    mmio_rdata = 64'(con_count);
            2'd1:    mmio_rdata = {tohost_code, tohost_valid};
            2'd2:    mmio_rdata = cycle_val;
            default: mmio_rdata = '0;
        endcase
    end

    assign dmem.dmem_rdata = ram_hit  ? ram_rdata  :
                             mmio_hit ? mmio_rdata : '0;
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Self-checking bench for riscv_dmem_responder: directed plan plus randomized traffic vs a byte-level model.
module tb_riscv_dmem_responder;
    localparam int unsigned MEM_BYTES = 65536;
    localparam logic [63:0] MMIO = 64'h0000_0000_1000_0000;
    localparam logic [63:0] CONS = MMIO;
    localparam logic [63:0] TOH  = MMIO + 64'd8;
    localparam logic [63:0] CYC  = MMIO + 64'd16;
    localparam logic [63:0] UNM  = 64'h0000_0000_2000_0000;
`ifdef RISCV_DMEM_CYCLE_EN
    localparam logic [63:0] CYC10 = 64'd10;
`else
    localparam logic [63:0] CYC10 = 64'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        con_ready = 1'b0;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_overflow;
    logic        tohost_valid;
    logic [62:0] tohost_code;

    riscv_dmem_responder_if dif ();

    riscv_dmem_responder #(
        .MEM_BYTES(MEM_BYTES),
        .CON_DEPTH(8),
        .MMIO_BASE(MMIO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dmem(dif),
        .con_valid(con_valid),
        .con_data(con_data),
        .con_ready(con_ready),
        .con_overflow(con_overflow),
        .tohost_valid(tohost_valid),
        .tohost_code(tohost_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: RAM as bytes, FIFO as a queue
    logic [7:0]  mram [longint unsigned];
    logic [7:0]  q [$];
    bit          m_ovf = 0;
    bit          m_tv = 0;
    logic [62:0] m_tc = '0;
    logic [63:0] m_cyc = '0;
    bit          m_live = 0;

    function automatic bit model_read(input logic [63:0] a, input logic [2:0] sz,
                                      output logic [63:0] v);
        int unsigned n;
        logic [63:0] base;
        bit known;
        n = 1 << sz[1:0];
        base = a - (a % n);
        v = '0;
        known = 1;
        if (a < MEM_BYTES) begin
            for (int i = 0; i < int'(n); i++) begin
                if (!mram.exists(base + i)) known = 0;
                else v |= 64'(mram[base + i]) << (8 * i);
            end
            if (!sz[2] && sz[1:0] != 2'd3 && v[8*n-1]) v |= ~64'd0 << (8 * n);
        end else if (a >= MMIO && a < MMIO + 64'd32) begin
            case ((a - MMIO) / 8)
                0: v = 64'(q.size());
                1: v = {m_tc, m_tv};
`ifdef RISCV_DMEM_CYCLE_EN
                2: v = m_cyc;
`endif
                default: v = '0;
            endcase
        end
        return known;
    endfunction

    initial begin : model_update
        logic [63:0] a, base;
        int unsigned n;
        bit pop;
        forever begin
            @(posedge clk);
            a   = dif.dmem_addr;
            pop = (q.size() != 0) && (con_ready === 1'b1);
            if (dif.dmem_we && a < MEM_BYTES) begin
                n = 1 << dif.dmem_size[1:0];
                base = a - (a % n);
                for (int i = 0; i < int'(n); i++) mram[base + i] = dif.dmem_wdata[8*i +: 8];
            end
            if (rst) begin
                q.delete();
                m_ovf = 0; m_tv = 0; m_tc = '0; m_cyc = '0; m_live = 1;
            end else if (m_live) begin
                m_cyc = m_cyc + 64'd1;
                if (pop) void'(q.pop_front());
                if (dif.dmem_we && a >= MMIO && a < MMIO + 64'd32) begin
                    if ((a - MMIO) / 8 == 0) begin
                        if (q.size() < 8) q.push_back(dif.dmem_wdata[7:0]);
                        else m_ovf = 1;
                    end else if ((a - MMIO) / 8 == 1) begin
                        if (dif.dmem_wdata[0] && !m_tv) begin
                            m_tv = 1;
                            m_tc = dif.dmem_wdata[63:1];
                        end
                    end
                end
            end
        end
    end

    initial begin : compare
        logic [63:0] ev;
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("m_con_valid", 64'(con_valid), 64'(q.size() != 0));
                check("m_con_data", 64'(con_data), (q.size() != 0) ? 64'(q[0]) : 64'd0);
                check("m_con_overflow", 64'(con_overflow), 64'(m_ovf));
                check("m_tohost_valid", 64'(tohost_valid), 64'(m_tv));
                check("m_tohost_code", 64'(tohost_code), 64'(m_tc));
                if (model_read(dif.dmem_addr, dif.dmem_size, ev))
                    check("m_rdata", dif.dmem_rdata, ev);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] d, input logic we, input logic [2:0] sz);
        dif.dmem_addr  = a;
        dif.dmem_wdata = d;
        dif.dmem_we    = we;
        dif.dmem_size  = sz;
        #1;
    endtask

    task automatic load_check(input string name, input logic [63:0] a, input logic [2:0] sz,
                              input logic [63:0] exp);
        drive(a, '0, 1'b0, sz);
        check(name, dif.dmem_rdata, exp);
        tick();
    endtask

    initial begin
        drive(UNM, '0, 1'b0, 3'd3);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("rst_con_valid", 64'(con_valid), 64'd0);
        check("rst_con_data", 64'(con_data), 64'd0);
        check("rst_overflow", 64'(con_overflow), 64'd0);
        check("rst_tohost_valid", 64'(tohost_valid), 64'd0);
        check("rst_tohost_code", 64'(tohost_code), 64'd0);
        drive(CYC, '0, 1'b0, 3'd3);
        check("cycle_first", dif.dmem_rdata, 64'd0);
        repeat (10) tick();
        drive(CYC, '0, 1'b0, 3'd3);
        check("cycle_10", dif.dmem_rdata, CYC10);
        tick();

        // Store/load widths
        drive(64'h100, 64'h8877_6655_4433_2211, 1'b1, 3'd3);
        tick();
        load_check("LB_107",  64'h107, 3'd0, 64'hFFFF_FFFF_FFFF_FF88);
        load_check("LBU_107", 64'h107, 3'd4, 64'h0000_0000_0000_0088);
        load_check("LH_106",  64'h106, 3'd1, 64'hFFFF_FFFF_FFFF_8877);
        load_check("LW_104",  64'h104, 3'd2, 64'hFFFF_FFFF_8877_6655);
        load_check("LWU_104", 64'h104, 3'd6, 64'h0000_0000_8877_6655);
        load_check("LH_mis",  64'h107, 3'd1, 64'hFFFF_FFFF_FFFF_8877);

        // Partial store; same-cycle read sees old byte
        drive(64'h101, 64'h0000_0000_0000_00AB, 1'b1, 3'd0);
        check("SB_same_cycle", dif.dmem_rdata, 64'h0000_0000_0000_0022);
        tick();
        load_check("LD_after_SB", 64'h100, 3'd3, 64'h8877_6655_4433_AB11);

        // TOHOST
        drive(TOH, 64'h3, 1'b1, 3'd3);
        check("tohost_same_cycle", 64'(tohost_valid), 64'd0);
        tick();
        drive(UNM, '0, 1'b0, 3'd3);
        check("tohost_valid", 64'(tohost_valid), 64'd1);
        check("tohost_code", 64'(tohost_code), 64'd1);
        tick();
        drive(TOH, 64'h5, 1'b1, 3'd0);
        tick();
        load_check("tohost_read", TOH, 3'd0, 64'h3);
        drive(UNM, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd3);
        check("unmapped_read", dif.dmem_rdata, 64'd0);
        tick();
        load_check("unmapped_after_write", UNM, 3'd3, 64'd0);
        check("tohost_code_kept", 64'(tohost_code), 64'd1);

        // Console overflow
        con_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(CONS, 64'(8'h41 + i), 1'b1, 3'd0);
            tick();
        end
        drive(CONS, '0, 1'b0, 3'd3);
        check("ovf_flag", 64'(con_overflow), 64'd1);
        check("ovf_occupancy", dif.dmem_rdata, 64'd8);
        con_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("drain_valid", 64'(con_valid), 64'd1);
            check("drain_data", 64'(con_data), 64'(8'h41 + i));
            tick();
        end
        check("drain_empty", 64'(con_valid), 64'd0);
        con_ready = 1'b0;

        // Reset with queued bytes; coincident store lands, coincident MMIO write does not
        for (int i = 0; i < 3; i++) begin
            drive(CONS, 64'(8'h30 + i), 1'b1, 3'd0);
            tick();
        end
        rst = 1'b1;
        drive(64'h180, 64'hDEAD_BEEF_0123_4567, 1'b1, 3'd3);
        tick();
        drive(TOH, 64'h7, 1'b1, 3'd3);
        tick();
        rst = 1'b0;
        drive(UNM, '0, 1'b0, 3'd3);
        check("rst_mid_valid", 64'(con_valid), 64'd0);
        check("rst_mid_ovf", 64'(con_overflow), 64'd0);
        check("rst_mid_tohost", 64'(tohost_valid), 64'd0);
        tick();
        load_check("rst_ram_kept", 64'h100, 3'd3, 64'h8877_6655_4433_AB11);
        load_check("rst_store", 64'h180, 3'd3, 64'hDEAD_BEEF_0123_4567);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            drive(CONS, 64'(8'h61 + i), 1'b1, 3'd0);
            tick();
        end
        con_ready = 1'b1;
        drive(CONS, 64'h5A, 1'b1, 3'd0);
        tick();
        con_ready = 1'b0;
        drive(CONS, '0, 1'b0, 3'd3);
        check("pp_occupancy", dif.dmem_rdata, 64'd8);
        check("pp_ovf", 64'(con_overflow), 64'd0);
        con_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("pp_drain", 64'(con_data), (i < 7) ? 64'(8'h62 + i) : 64'h5A);
            tick();
        end
        check("pp_empty", 64'(con_valid), 64'd0);
        con_ready = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 8; i++) begin
            drive(64'h100 + 64'(8 * i), {$urandom, $urandom}, 1'b1, 3'd3);
            tick();
        end
        repeat (3000) begin
            int unsigned pick;
            logic [63:0] a;
            rst = ($urandom_range(0, 199) == 0);
            con_ready = $urandom_range(0, 1) == 1;
            pick = $urandom_range(0, 9);
            if (pick < 6)      a = 64'h100 + 64'($urandom_range(0, 63));
            else if (pick < 9) a = MMIO + 64'($urandom_range(0, 31));
            else               a = {1'b1, 31'($urandom), 32'($urandom)};
            drive(a, {$urandom, $urandom}, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
